// File: rtl/multdiv_sequencer.sv
// Iterative signed 32-bit multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide on magnitudes; stalls the pipeline while in flight.
module multdiv_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_op,
    input  logic [WIDTH-1:0] i_operand_a,
    input  logic [WIDTH-1:0] i_operand_b,
    output logic             o_stall,
    output logic             o_busy,
    output logic             o_result_valid,
    output logic [WIDTH-1:0] o_result,
    output logic             o_exception,
    output logic [31:0]      o_status_code
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e             r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_op;
    logic               r_sign;
    logic [WIDTH-1:0]   r_mag_a;
    logic [WIDTH-1:0]   r_mag_b;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_valid;
    logic [WIDTH-1:0]   r_result;
    logic               r_exception;
    logic [31:0]        r_status;

    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_add;
    logic [2*WIDTH-1:0] w_mul_acc;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_ge;
    logic [WIDTH-1:0]   w_sub;
    logic [2*WIDTH-1:0] w_div_acc;
    logic [2*WIDTH-1:0] w_acc_nx;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic               w_mul_ovf;
    logic               w_last;

    assign w_mag_a = i_operand_a[WIDTH-1] ? -i_operand_a : i_operand_a;
    assign w_mag_b = i_operand_b[WIDTH-1] ? -i_operand_b : i_operand_b;

    // Multiply: add multiplicand into the high half, then shift the whole accumulator right.
    assign w_add     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_mag_b[0] ? {1'b0, r_mag_a} : '0);
    assign w_mul_acc = {w_add, r_acc[WIDTH-1:1]};

    // Divide: high half is the partial remainder, low half shifts dividend out / quotient in.
    assign w_rem_sh  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_mag_b});
    assign w_sub     = w_rem_sh[WIDTH-1:0] - r_mag_b;
    assign w_div_acc = w_ge ? {w_sub, r_acc[WIDTH-2:0], 1'b1}
                            : {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

    assign w_acc_nx  = r_op ? w_div_acc : w_mul_acc;
    assign w_prod    = r_sign ? -w_acc_nx : w_acc_nx;
    assign w_quot    = r_sign ? -w_acc_nx[WIDTH-1:0] : w_acc_nx[WIDTH-1:0];
    assign w_mul_ovf = (w_prod[2*WIDTH-1:WIDTH-1] != '0) && (w_prod[2*WIDTH-1:WIDTH-1] != '1);
    assign w_last    = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_op        <= 1'b0;
            r_sign      <= 1'b0;
            r_mag_a     <= '0;
            r_mag_b     <= '0;
            r_acc       <= '0;
            r_valid     <= 1'b0;
            r_result    <= '0;
            r_exception <= 1'b0;
            r_status    <= '0;
        end else begin
            r_valid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_op    <= i_op;
                        r_sign  <= i_operand_a[WIDTH-1] ^ i_operand_b[WIDTH-1];
                        r_mag_a <= w_mag_a;
                        r_mag_b <= w_mag_b;
                        r_cnt   <= '0;
                        r_acc   <= i_op ? {{WIDTH{1'b0}}, w_mag_a} : '0;
                        if (i_op && (i_operand_b == '0)) begin
                            r_state     <= StDone;
                            r_valid     <= 1'b1;
                            r_result    <= '0;
                            r_exception <= 1'b1;
                            r_status    <= 32'd2;
                        end else begin
                            r_state <= StBusy;
                        end
                    end
                end
                StBusy: begin
                    r_acc <= w_acc_nx;
                    r_cnt <= r_cnt + CW'(1);
                    if (!r_op) begin
                        r_mag_b <= r_mag_b >> 1;
                    end
                    if (w_last) begin
                        r_state <= StDone;
                        r_valid <= 1'b1;
                        if (r_op) begin
                            r_result    <= w_quot;
                            r_exception <= 1'b0;
                            r_status    <= 32'd0;
                        end else begin
                            r_result    <= w_prod[WIDTH-1:0];
                            r_exception <= w_mul_ovf;
                            r_status    <= w_mul_ovf ? 32'd1 : 32'd0;
                        end
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Stall is combinational on start so the pipeline freezes in the issue cycle itself.
    assign o_stall        = ((r_state == StIdle) && i_start) || (r_state == StBusy);
    assign o_busy         = (r_state == StBusy);
    assign o_result_valid = r_valid;
    assign o_result       = r_result;
    assign o_exception    = r_exception;
    assign o_status_code  = r_status;

endmodule
